// File: rtl/axi_mem_slave_ram_if.sv
// Memory-side request/response bundle between axi_top and the SRAM target.
// The master drives requests; the slave returns read data, error and init status.
interface axi_mem_slave_ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_err;
    logic [ADDR_W-1:0] err_addr;
    logic              init_busy;

    modport master (
        output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        input  mem_rd_data, mem_rd_valid, mem_err, err_addr, init_busy
    );

    modport slave (
        input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
        output mem_rd_data, mem_rd_valid, mem_err, err_addr, init_busy
    );
endinterface

// File: rtl/axi_mem_slave_ram.sv
// Word-addressed SRAM target with fixed RD_LAT read pipeline and out-of-window error flagging.
// Optional MEM_CLR_ON_RST_EN: zero-fill sweep of the array after each reset release.
module axi_mem_slave_ram #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h02020000,
    parameter int                RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    axi_mem_slave_ram_if.slave bus
);
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(DEPTH * 4);
    localparam logic [DATA_W-1:0] OOW_DATA  = DATA_W'(32'hDEADBEEF);

    // Offset subtraction wraps below BASE_ADDR, so one unsigned compare covers both bounds.
    logic [ADDR_W-1:0] wr_off, rd_off;
    logic              wr_win, rd_win;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    assign wr_off = bus.mem_wr_addr - BASE_ADDR;
    assign rd_off = bus.mem_rd_addr - BASE_ADDR;
    assign wr_win = wr_off < WIN_BYTES;
    assign rd_win = rd_off < WIN_BYTES;
    assign wr_idx = wr_off[IDX_W+1:2];
    assign rd_idx = rd_off[IDX_W+1:2];

    logic             busy;
    logic             clr_we;
    logic [IDX_W-1:0] clr_idx;

`ifdef MEM_CLR_ON_RST_EN
    typedef enum logic {IDLE, CLEAR} clr_state_e;
    clr_state_e       state_q, state_d;
    logic             rst_q;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // rst_q high in a non-reset cycle marks the reset release edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rst_q) state_d = CLEAR;
            CLEAR:   if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == CLEAR);
        clr_we    = busy;
        clr_idx   = clr_idx_q;
        clr_idx_d = busy ? clr_idx_q + IDX_W'(1) : '0;
    end
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    logic wr_acc, rd_acc, wr_err, rd_err;

    assign wr_acc = bus.mem_wr_en & wr_win & ~busy;
    assign rd_acc = bus.mem_rd_en & ~busy;
    assign wr_err = bus.mem_wr_en & (~wr_win | busy);
    assign rd_err = bus.mem_rd_en & (~rd_win | busy);

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] rd_word;

    // Read sample uses the pre-edge array value, giving read-first on same-index collisions.
    assign rd_word = rd_win ? ram_q[rd_idx] : OOW_DATA;

    always_ff @(posedge clk) begin
        if (clr_we)
            ram_q[clr_idx] <= '0;
        else if (wr_acc)
            ram_q[wr_idx] <= bus.mem_wr_data;
    end

    logic [RD_LAT-1:0] vld_pipe_q, vld_in;
    logic [DATA_W-1:0] dat_pipe_q [RD_LAT];
    logic [DATA_W-1:0] dat_in     [RD_LAT];

    always_comb begin
        vld_in = '0;
        for (int k = 0; k < RD_LAT; k++) dat_in[k] = '0;
        vld_in[0] = rd_acc;
        dat_in[0] = rd_word;
        for (int k = 1; k < RD_LAT; k++) begin
            vld_in[k] = vld_pipe_q[k-1];
            dat_in[k] = dat_pipe_q[k-1];
        end
    end

    // Last stage doubles as the output register and only loads on a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            for (int k = 0; k < RD_LAT; k++) dat_pipe_q[k] <= '0;
        end else begin
            vld_pipe_q <= vld_in;
            for (int k = 0; k < RD_LAT; k++)
                if (vld_in[k] || k != RD_LAT - 1) dat_pipe_q[k] <= dat_in[k];
        end
    end

    logic              mem_err_q, mem_err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    always_comb begin
        mem_err_d  = wr_err | rd_err;
        err_addr_d = err_addr_q;
        if (rd_err)
            err_addr_d = bus.mem_rd_addr;
        else if (wr_err)
            err_addr_d = bus.mem_wr_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            mem_err_q  <= mem_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.mem_rd_valid = vld_pipe_q[RD_LAT-1];
    assign bus.mem_rd_data  = dat_pipe_q[RD_LAT-1];
    assign bus.mem_err      = mem_err_q;
    assign bus.err_addr     = err_addr_q;
    assign bus.init_busy    = busy;
endmodule

// File: tb/tb_axi_mem_slave_ram.sv
// Bench for axi_mem_slave_ram: RD_LAT=1/DEPTH=256 instance driven from a vector table,
// RD_LAT=3/DEPTH=16 instance for pipelining, reset flush and optional clear sweep.
module tb_axi_mem_slave_ram;
    localparam logic [31:0] BASE = 32'h02020000;

    logic clk = 1'b0;
    logic rst1, rst3;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    axi_mem_slave_ram_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    axi_mem_slave_ram_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

    axi_mem_slave_ram #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .BASE_ADDR(BASE), .RD_LAT(1))
        u_dut1 (.clk(clk), .rst(rst1), .bus(if1));
    axi_mem_slave_ram #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .BASE_ADDR(BASE), .RD_LAT(3))
        u_dut3 (.clk(clk), .rst(rst3), .bus(if3));

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        rd;
        logic [31:0] ra;
        logic [31:0] rdat;
        logic        err;
        logic [31:0] eaddr;
    } vec_t;

    exp_t q1[$], q3[$];
    exp_t e1, e3;
    vec_t tv[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Every valid beat must match the oldest scoreboard entry in both data and cycle.
    always @(negedge clk) begin
        if (if1.mem_rd_valid === 1'b1) begin
            if (q1.size() == 0) check("dut1 unexpected valid", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("dut1 rd data", if1.mem_rd_data, e1.data);
                check("dut1 rd cycle", cyc, e1.due);
            end
        end
        if (if3.mem_rd_valid === 1'b1) begin
            if (q3.size() == 0) check("dut3 unexpected valid", 32'd1, 32'd0);
            else begin
                e3 = q3.pop_front();
                check("dut3 rd data", if3.mem_rd_data, e3.data);
                check("dut3 rd cycle", cyc, e3.due);
            end
        end
    end

    task automatic idle1();
        if1.mem_wr_en = 1'b0; if1.mem_wr_addr = '0; if1.mem_wr_data = '0;
        if1.mem_rd_en = 1'b0; if1.mem_rd_addr = '0;
    endtask

    task automatic idle3();
        if3.mem_wr_en = 1'b0; if3.mem_wr_addr = '0; if3.mem_wr_data = '0;
        if3.mem_rd_en = 1'b0; if3.mem_rd_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr3(input logic [31:0] a, input logic [31:0] d);
        if3.mem_wr_en = 1'b1; if3.mem_wr_addr = a; if3.mem_wr_data = d;
        step();
        idle3();
    endtask

    task automatic rd3(input logic [31:0] a, input logic [31:0] exp);
        if3.mem_rd_en = 1'b1; if3.mem_rd_addr = a;
        step();
        q3.push_back('{exp, cyc + 2});
        idle3();
    endtask

    int busy_cnt;

    initial begin
        tv[0]  = '{1'b1, 32'h02020202, 32'h00001111, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        tv[1]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h02020202, 32'h00001111, 1'b0, 32'h0};
        tv[2]  = '{1'b1, 32'h02020010, 32'h00000001, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
        tv[3]  = '{1'b1, 32'h02020010, 32'hA5A5A5A5, 1'b1, 32'h02020010, 32'h00000001, 1'b0, 32'h0};
        tv[4]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h02020013, 32'hA5A5A5A5, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 32'h02020400, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b1, 32'h02020400};
        tv[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h01FFFFFC, 32'hDEADBEEF, 1'b1, 32'h01FFFFFC};
        tv[7]  = '{1'b1, 32'h020203FC, 32'hCAFEF00D, 1'b0, 32'h0,        32'h0,        1'b0, 32'h01FFFFFC};
        tv[8]  = '{1'b1, 32'h02020000, 32'h0000ABCD, 1'b1, 32'h020203FF, 32'hCAFEF00D, 1'b0, 32'h01FFFFFC};
        tv[9]  = '{1'b1, 32'h02020400, 32'h77777777, 1'b1, 32'h02020800, 32'hDEADBEEF, 1'b1, 32'h02020800};
        tv[10] = '{1'b0, 32'h0,        32'h0,        1'b1, 32'h02020000, 32'h0000ABCD, 1'b0, 32'h02020800};
        tv[11] = '{1'b1, 32'hFFFFFFFC, 32'h00000001, 1'b0, 32'h0,        32'h0,        1'b1, 32'hFFFFFFFC};

        idle1();
        idle3();
        rst1 = 1'b1;
        rst3 = 1'b1;
        repeat (3) step();
        check("rst dut1 rd_data",   if1.mem_rd_data,  32'h0);
        check("rst dut1 rd_valid",  if1.mem_rd_valid, 32'h0);
        check("rst dut1 mem_err",   if1.mem_err,      32'h0);
        check("rst dut1 err_addr",  if1.err_addr,     32'h0);
        check("rst dut1 init_busy", if1.init_busy,    32'h0);
        check("rst dut3 rd_data",   if3.mem_rd_data,  32'h0);
        check("rst dut3 rd_valid",  if3.mem_rd_valid, 32'h0);
        check("rst dut3 err_addr",  if3.err_addr,     32'h0);
        rst1 = 1'b0;
        rst3 = 1'b0;
        step();
        for (int i = 0; i < 100 && (if1.init_busy || if3.init_busy); i++) step();
        check("dut1 init done", if1.init_busy, 32'h0);
        check("dut3 init done", if3.init_busy, 32'h0);

        for (int i = 0; i < 12; i++) begin
            if1.mem_wr_en   = tv[i].wr;
            if1.mem_wr_addr = tv[i].wa;
            if1.mem_wr_data = tv[i].wd;
            if1.mem_rd_en   = tv[i].rd;
            if1.mem_rd_addr = tv[i].ra;
            step();
            if (tv[i].rd) q1.push_back('{tv[i].rdat, cyc});
            idle1();
            check($sformatf("vec%0d mem_err", i),  if1.mem_err,  tv[i].err);
            check($sformatf("vec%0d err_addr", i), if1.err_addr, tv[i].eaddr);
        end
        repeat (3) step();

        // RD_LAT=3: back-to-back reads return on consecutive cycles in issue order.
        for (int k = 0; k < 4; k++) wr3(BASE + 32'(4 * k), 32'(10 + k));
        wr3(BASE + 32'h14, 32'h00000055);
        for (int k = 0; k < 4; k++) rd3(BASE + 32'(4 * k), 32'(10 + k));
        repeat (6) step();
        check("dut3 held data",  if3.mem_rd_data,  32'd13);
        check("dut3 valid low",  if3.mem_rd_valid, 32'd0);
        rd3(BASE + 32'h40, 32'hDEADBEEF);
        check("dut3 oow mem_err",  if3.mem_err,  32'd1);
        check("dut3 oow err_addr", if3.err_addr, BASE + 32'h40);
        step();
        check("dut3 mem_err pulse", if3.mem_err, 32'd0);
        repeat (4) step();

        // Two reads in flight when reset hits must never surface.
        if3.mem_rd_en = 1'b1; if3.mem_rd_addr = BASE;
        step();
        if3.mem_rd_addr = BASE + 32'h4;
        step();
        idle3();
        rst3 = 1'b1;
        step();
        step();
        check("flush rd_data",  if3.mem_rd_data,  32'h0);
        check("flush rd_valid", if3.mem_rd_valid, 32'h0);
        check("flush mem_err",  if3.mem_err,      32'h0);
        check("flush err_addr", if3.err_addr,     32'h0);
        rst3 = 1'b0;

`ifdef MEM_CLR_ON_RST_EN
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if3.mem_rd_en   = (i == 2);
            if3.mem_rd_addr = (i == 2) ? BASE + 32'h14 : 32'h0;
            if (i == 3) begin
                check("sweep drop mem_err",  if3.mem_err,  32'd1);
                check("sweep drop err_addr", if3.err_addr, BASE + 32'h14);
            end
            if (if3.init_busy) busy_cnt++;
        end
        check("sweep busy cycles", busy_cnt, 32'd16);
        rd3(BASE + 32'h14, 32'h0);
        rd3(BASE, 32'h0);
`else
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (if3.init_busy) busy_cnt++;
        end
        check("no sweep busy", busy_cnt, 32'd0);
        rd3(BASE + 32'h14, 32'h00000055);
        rd3(BASE, 32'd10);
`endif
        repeat (6) step();
        check("dut1 queue drained", q1.size(), 32'd0);
        check("dut3 queue drained", q3.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
